digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder and successor to the 4-bit ripple full adder. It adds two WIDTH-bit operands DIGIT bits per clock, and the carry is held in a register between digits. A start/busy/done handshake lets wide adds run on a small datapath slice inside the arithmetic units. Results, carry-out and signed overflow are registered and held until the next operation completes.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits added per clock cycle (slice width); 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
nr1  input  WIDTH  operand A; sampled on the accepting edge
nr2  input  WIDTH  operand B; sampled on the accepting edge
cin  input  1  carry-in; sampled on the accepting edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; out/cout/ovf are valid from this cycle on
out  output  WIDTH  registered sum
cout  output  1  registered carry-out of bit WIDTH-1
ovf  output  1  registered signed overflow (carry into MSB xor carry out of MSB)

Behaviour:
- N = WIDTH/DIGIT. Internal state:
  - opA/opB operand latches
  - carry register
  - digit counter, clog2(N) bits, min 1
  - result shift register
  - FSM states IDLE and RUN
- Reset (rst=1 at an edge) overrides everything and sets:
  - state=IDLE, busy=0, done=0
  - out=0, cout=0, ovf=0
  - counter=0, carry=0
- Reset mid-RUN aborts the operation: no done pulse, and the partial result is discarded.
- IDLE, with start=1 at an edge:
  - Latch nr1, nr2 and cin; carry<=cin; counter<=0.
  - Go to RUN; busy<=1.
  - With start=0, stay in IDLE.
- RUN, on each edge:
  - Digit k=counter. Compute opA[k*DIGIT+:DIGIT] + opB[k*DIGIT+:DIGIT] + carry.
  - Store the digit sum into the result register at slice k.
  - Store the digit carry-out into the carry register.
  - counter increments.
- RUN, on the edge processing k=N-1:
  - Load out with the full result.
  - cout <= final carry.
  - ovf <= (carry into bit WIDTH-1) xor (carry out of bit WIDTH-1).
  - busy<=0, done<=1, state<=IDLE.
- Latency: done is high after exactly N+1 rising edges, counting the accepting edge as edge 1. Throughput is one operation per N+1 cycles.
- done is high for exactly one cycle; done=1 implies busy=0.
- out, cout and ovf change only at completion or reset. They hold the previous result throughout RUN.
- start while busy=1 is ignored: no queuing, operands are not re-sampled.
- start=1 in the done cycle is accepted (back-to-back operation).
- nr1, nr2 and cin may change freely after the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH. For WIDTH=DIGIT the block reduces to a single-cycle slice with N=1.

Optional Feature:
- Macro SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - sub=1 computes nr1 - nr2 - cin: opB latched as ~nr2, initial carry = ~cin.
  - In subtract mode cout=1 means no borrow.
  - ovf is the signed subtraction overflow under the same MSB-carry rule.
  - sub=0 behaves exactly as the base block.
- Not defined: no sub port; addition only.

Test Plan:
1. rst=1 for 2 cycles with random inputs and start=1 -> busy=0, done=0, out=0x0000, cout=0, ovf=0; no operation starts.
2. WIDTH=16, DIGIT=4: start with nr1=0x1234, nr2=0x4321, cin=0 -> busy=1 for 4 cycles, done on edge 5, out=0x5555, cout=0, ovf=0; out holds 0x5555 after done.
3. nr1=0xFFFF, nr2=0x0001, cin=0 (carry crosses every digit) -> out=0x0000, cout=1, ovf=0. nr1=0x7FFF, nr2=0x0001 -> out=0x8000, cout=0, ovf=1.
4. Start 0x0001+0x0002. While busy, pulse start with 0xAAAA+0x5555 -> ignored, result 0x0003. Assert start in the done cycle with 0x00FF+0x0001, cin=1 -> accepted, next done 5 edges later with out=0x0101.
5. Start 0x8000+0x8000 after an earlier result of 0x0003, then rst=1 on edge 3 -> busy=0, no done pulse, out=0x0000, cout=0. A following start 0x0010+0x0020 gives out=0x0030.
6. SUB_EN defined, DIGIT=1 (N=16): sub=1 with 0x0005-0x0007, cin=0 -> done on edge 17, out=0xFFFE, cout=0, ovf=0. sub=1 with 0x8000-0x0001 -> out=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands DIGIT bits per clock with a
// carry register between digits and a start/busy/done handshake.
// Optional build macro SUB_EN adds a 'sub' port for nr1 - nr2 - cin.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] nr1,
  input  logic [WIDTH-1:0] nr2,
  input  logic             cin,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] opa, opb, res;
  logic [WIDTH-1:0] opb_in;
  logic             carry_in;
  logic             accept, last;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic [WIDTH-1:0] res_full;

  // One digit slice: {carry_out, sum}.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             c);
    return {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, c};
  endfunction

  // Carry into a bit recovered from its operand bits and sum bit.
  function automatic logic carry_into(input logic a, input logic b, input logic s);
    return a ^ b ^ s;
  endfunction

`ifdef SUB_EN
  // Subtraction is addition of the inverted operand with inverted carry-in.
  assign opb_in   = sub ? ~nr2 : nr2;
  assign carry_in = sub ? ~cin : cin;
`else
  assign opb_in   = nr2;
  assign carry_in = cin;
`endif

  assign accept   = (state == IDLE) && start;
  assign last     = (cnt == CW'(N - 1));
  assign busy     = (state == RUN);

  // Operands shift right each digit, so the active slice is always bits [DIGIT-1:0];
  // the sum digit enters the result register from the top.
  assign dsum     = digit_add(opa[DIGIT-1:0], opb[DIGIT-1:0], carry);
  assign msb_cin  = carry_into(opa[DIGIT-1], opb[DIGIT-1], dsum[DIGIT-1]);
  assign res_full = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: IDLE waits for start, RUN ends after the top digit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers: digit counter, carry, done pulse, outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt   <= '0;
        carry <= carry_in;
      end else if (state == RUN) begin
        carry <= dsum[DIGIT];
        cnt   <= last ? '0 : cnt + CW'(1);
        if (last) begin
          out  <= res_full;
          cout <= dsum[DIGIT];
          ovf  <= msb_cin ^ dsum[DIGIT];
          done <= 1'b1;
        end
      end
    end
  end

  // Datapath: operand latches and partial-result shift register (no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= nr1;
      opb <= opb_in;
    end else if (state == RUN) begin
      opa <= opa >> DIGIT;
      opb <= opb >> DIGIT;
      res <= res_full;
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder (16-bit; DIGIT=1 when SUB_EN is defined).
module tb_digit_serial_adder;

`ifdef SUB_EN
  localparam int DIGIT = 1;
`else
  localparam int DIGIT = 4;
`endif
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / DIGIT;

  logic             clk, rst, start, cin;
  logic [WIDTH-1:0] nr1, nr2;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] out;
`ifdef SUB_EN
  logic             sub;
`endif

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] prev_out;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        s;
    logic [15:0] eo;
    logic        ec;
    logic        ev;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .nr1   (nr1),
    .nr2   (nr2),
    .cin   (cin),
`ifdef SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .out   (out),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic s);
    nr1 = a;
    nr2 = b;
    cin = ci;
`ifdef SUB_EN
    sub = s;
`else
    if (s) $display("note: sub ignored in add-only build");
`endif
  endtask

  // Called at the negedge after accepting edge number cyc0; returns at the done negedge.
  task automatic finish_op(input string nm, input int cyc0, input logic [15:0] eo,
                           input logic ec, input logic ev);
    int cyc;
    cyc = cyc0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_hold"}, 32'(out), 32'(prev_out));
    while (!done && cyc < N + 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_lat"}, 32'(cyc), 32'(N + 1));
    chk({nm, "_out"}, 32'(out), 32'(eo));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf), 32'(ev));
    chk({nm, "_busy0"}, 32'(busy), 32'd0);
    prev_out = eo;
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk);
    drive(v.a, v.b, v.ci, v.s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    finish_op(v.nm, 1, v.eo, v.ec, v.ev);
    @(negedge clk);
    chk({v.nm, "_pulse"}, 32'(done), 32'd0);
    chk({v.nm, "_keep"}, 32'(out), 32'(v.eo));
  endtask

  initial begin
    bit seen;
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_5555"});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple"});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "posovf"});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "cinonly"});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "negovf"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "allones"});
`ifdef SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg"});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, "sub_bin"});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "sub0_add"});
`endif

    // Reset with start held high and random operands.
    rst   = 1'b1;
    start = 1'b1;
    drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    prev_out = '0;

    // Table-driven operations.
    foreach (vecs[i]) run_op(vecs[i]);

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    drive(16'h0001, 16'h0002, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    drive(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    finish_op("busy_ign", 2, 16'h0003, 1'b0, 1'b0);
    drive(16'h00FF, 16'h0001, 1'b1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("b2b", 1, 16'h0101, 1'b0, 1'b0);

    // Reset mid-operation aborts with no done pulse.
    run_op('{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, "pre_abort"});
    @(negedge clk);
    drive(16'h8000, 16'h8000, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out", 32'(out), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    prev_out = '0;
    run_op('{16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, "post_abort"});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
